// File: rtl/aes_inv_cipher_ctrl_if.sv
// Handshake and datapath bundle for the AES inverse-cipher controller.
//   slave  : the controller. It takes start/cipher_in/out_ready, the round key and the
//            results of the three external combinational units. It drives ready,
//            key_addr, dp_state, plain_out, out_valid and cur_round.
//   master : the surrounding logic, which sees the same signals in the other direction.
// Every 128-bit block is numbered MSB-first: bits [127:120] hold byte 0 of the AES state.
interface aes_inv_cipher_ctrl_if;
  logic         start;
  logic [127:0] cipher_in;
  logic         ready;
  logic [3:0]   key_addr;
  logic [127:0] key_in;
  logic [127:0] dp_state;
  logic [127:0] isr_in;
  logic [127:0] isb_in;
  logic [127:0] imc_in;
  logic [127:0] plain_out;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   cur_round;

  modport slave (
    input  start, cipher_in, key_in, isr_in, isb_in, imc_in, out_ready,
    output ready, key_addr, dp_state, plain_out, out_valid, cur_round
  );

  modport master (
    output start, cipher_in, key_in, isr_in, isb_in, imc_in, out_ready,
    input  ready, key_addr, dp_state, plain_out, out_valid, cur_round
  );
endinterface

// File: rtl/aes_inv_cipher_ctrl.sv
// Round sequencer for the AES inverse cipher. It holds the 128-bit state register and the
// round counter. InvShiftRows, InvSubBytes and InvMixColumns are computed outside this
// block from dp_state. The round key is fetched from outside through key_addr.
// Ports:
//   clk     : clock. All state updates happen on its rising edge.
//   reset_n : asynchronous active-low reset. Release must already be synchronised to clk.
//   bus     : the handshake and datapath bundle (slave side).
// Schedule: IDLE -> ADD_INIT -> {ISR -> ISB -> ARK -> IMC} x (NR-1) -> ISR -> ISB -> ARK
// -> DONE. The result is therefore ready 4*NR edges after start is accepted.
module aes_inv_cipher_ctrl #(
  parameter int unsigned NR = 10  // legal values: 10, 12, 14
) (
  input logic                  clk,
  input logic                  reset_n,
  aes_inv_cipher_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAddInit,
    StIsr,
    StIsb,
    StArk,
    StImc,
    StDone
  } state_e;

  localparam logic [3:0] NrInit = 4'(NR);

  state_e       fsm_q;
  logic [127:0] state_q;
  logic [3:0]   round_q;
  logic         ready_q;
  logic         out_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      round_q     <= '0;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= bus.cipher_in;
            round_q <= NrInit;
            ready_q <= 1'b0;
            fsm_q   <= StAddInit;
          end
        end
        StAddInit: begin
          state_q <= state_q ^ bus.key_in;
          round_q <= round_q - 4'd1;
          fsm_q   <= StIsr;
        end
        StIsr: begin
          state_q <= bus.isr_in;
          fsm_q   <= StIsb;
        end
        StIsb: begin
          state_q <= bus.isb_in;
          fsm_q   <= StArk;
        end
        StArk: begin
          state_q <= state_q ^ bus.key_in;
          // round_q reaches 0 only here, on the final AddRoundKey. IMC is skipped.
          if (round_q == 4'd0) begin
            fsm_q       <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            fsm_q <= StImc;
          end
        end
        StImc: begin
          state_q <= bus.imc_in;
          round_q <= round_q - 4'd1;
          fsm_q   <= StIsr;
        end
        StDone: begin
          // state_q holds until the consumer takes the result
          if (bus.out_ready) begin
            fsm_q       <= StIdle;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          fsm_q <= StIdle;
        end
      endcase
    end
  end

  // The key index is only non-zero in the two AddRoundKey steps.
  assign bus.key_addr  = ((fsm_q == StAddInit) || (fsm_q == StArk)) ? round_q : 4'd0;
  assign bus.ready     = ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dp_state  = state_q;
  assign bus.plain_out = state_q;
  assign bus.cur_round = round_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Scoreboard bench for aes_inv_cipher_ctrl. It builds one instance with NR=10 and one
// with NR=14. The bench provides the reference InvShiftRows/InvSubBytes/InvMixColumns
// units and the expanded key schedules. A software inverse cipher computes the expected
// plaintext when a block is accepted. The result is compared when out_valid meets
// out_ready.
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] C1Ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3Ct = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Pt   = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [127:0] cipher_in = '0;
  logic         out_ready = 1'b0;
  logic         sel14 = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_out = 0;

  logic [127:0] exp_q[$];
  int           acc_cyc[$];
  logic [127:0] sb_exp;

  logic [127:0] rk10[0:15];
  logic [127:0] rk14[0:15];
  logic [31:0]  w[0:59];

  aes_inv_cipher_ctrl_if bus10 ();
  aes_inv_cipher_ctrl_if bus14 ();

  aes_inv_cipher_ctrl #(.NR(10)) u_dut10 (.clk(clk), .reset_n(reset_n), .bus(bus10));
  aes_inv_cipher_ctrl #(.NR(14)) u_dut14 (.clk(clk), .reset_n(reset_n), .bus(bus14));

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] p = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) r = gf_mul(r, p);
      p = gf_mul(p, p);
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(c*4+r) -: 8] = s[127-8*(((c-r+4)%4)*4+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] rk_of(input logic use14, input int r);
    return use14 ? rk14[r] : rk10[r];
  endfunction

  function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input logic use14);
    int nr;
    logic [127:0] s;
    nr = use14 ? 14 : 10;
    s = ct ^ rk_of(use14, nr);
    for (int r = nr - 1; r >= 1; r--) begin
      s = inv_mix_columns(inv_sub_bytes(inv_shift_rows(s)) ^ rk_of(use14, r));
    end
    return inv_sub_bytes(inv_shift_rows(s)) ^ rk_of(use14, 0);
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  // ---------------- reference units and key ROMs ----------------
  assign bus10.start     = start & ~sel14;
  assign bus14.start     = start & sel14;
  assign bus10.cipher_in = cipher_in;
  assign bus14.cipher_in = cipher_in;
  assign bus10.out_ready = out_ready & ~sel14;
  assign bus14.out_ready = out_ready & sel14;
  assign bus10.key_in    = rk10[bus10.key_addr];
  assign bus14.key_in    = rk14[bus14.key_addr];
  assign bus10.isr_in    = inv_shift_rows(bus10.dp_state);
  assign bus10.isb_in    = inv_sub_bytes(bus10.dp_state);
  assign bus10.imc_in    = inv_mix_columns(bus10.dp_state);
  assign bus14.isr_in    = inv_shift_rows(bus14.dp_state);
  assign bus14.isb_in    = inv_sub_bytes(bus14.dp_state);
  assign bus14.imc_in    = inv_mix_columns(bus14.dp_state);

  logic         ready_m, out_valid_m;
  logic [3:0]   key_addr_m, cur_round_m;
  logic [127:0] plain_m;
  assign ready_m     = sel14 ? bus14.ready : bus10.ready;
  assign out_valid_m = sel14 ? bus14.out_valid : bus10.out_valid;
  assign key_addr_m  = sel14 ? bus14.key_addr : bus10.key_addr;
  assign cur_round_m = sel14 ? bus14.cur_round : bus10.cur_round;
  assign plain_m     = sel14 ? bus14.plain_out : bus10.plain_out;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard. Inputs only change #1 after a rising edge, so the values seen at the
  // falling edge are the ones the next rising edge will act on.
  always @(negedge clk) begin
    if (reset_n) begin
      if (start && ready_m) begin
        exp_q.push_back(inv_cipher(cipher_in, sel14));
        acc_cyc.push_back(cyc);
      end
      if (out_valid_m && out_ready) begin
        check_eq("sb_has_entry", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          sb_exp = exp_q.pop_front();
          check_eq("sb_plain", plain_m, sb_exp);
          n_out++;
        end
      end
    end
  end

  // Start one block and wait for out_valid. Busy cycles get noise on start, cipher_in and
  // out_ready.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int nr);
    int         n;
    logic       seen;
    logic [3:0] last_ka;
    logic [3:0] nz[$];
    cipher_in = ct;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_ready", 128'(ready_m), 128'd0);
    n = 0;
    seen = 1'b0;
    last_ka = 4'd0;
    while (!seen && n < 4 * nr + 20) begin
      if (key_addr_m != 4'd0) nz.push_back(key_addr_m);
      last_ka = key_addr_m;
      cipher_in = {$urandom, $urandom, $urandom, $urandom};
      start = (n < 36) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (n < 36) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      n++;
      seen = out_valid_m;
    end
    check_eq("latency", 128'(n), 128'(4 * nr));
    check_eq("final_ark_key_addr", 128'(last_ka), 128'd0);
    check_eq("key_trace_len", 128'(nz.size()), 128'(nr));
    for (int i = 0; i < nz.size() && i < nr; i++)
      check_eq("key_trace", 128'(nz[i]), 128'(nr - i));
    check_eq("done_plain", plain_m, pt);
    check_eq("done_round", 128'(cur_round_m), 128'd0);
  endtask

  // Keep DONE waiting for `hold` cycles with start noise, then release it.
  task automatic drain(input int hold);
    logic [127:0] cap;
    cap = plain_m;
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom_range(0, 1));
      cipher_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check_eq("bp_valid", 128'(out_valid_m), 128'd1);
      check_eq("bp_plain", plain_m, cap);
      check_eq("bp_ready", 128'(ready_m), 128'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("release_valid", 128'(out_valid_m), 128'd0);
    check_eq("release_ready", 128'(ready_m), 128'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct;
    logic         changed;

    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    // Assert reset before the first clock edge, so only the asynchronous path can act.
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_ready", 128'(bus10.ready), 128'd1);
    check_eq("rst_valid", 128'(bus10.out_valid), 128'd0);
    check_eq("rst_key_addr", 128'(bus10.key_addr), 128'd0);
    check_eq("rst_plain", bus10.plain_out, 128'd0);
    check_eq("rst_round", 128'(bus10.cur_round), 128'd0);
    check_eq("rst14_ready", 128'(bus14.ready), 128'd1);
    check_eq("rst14_plain", bus14.plain_out, 128'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_ready", 128'(ready_m), 128'd1);

    // FIPS-197 C.1, released immediately
    run_block(C1Ct, Pt, 10);
    drain(0);

    // backpressure: DONE held for 20 cycles
    run_block(C1Ct, Pt, 10);
    drain(20);

    // random ciphertexts checked against the software model
    for (int k = 0; k < 3; k++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      run_block(ct, inv_cipher(ct, 1'b0), 10);
      drain($urandom_range(0, 3));
    end

    // back-to-back with start and out_ready held high
    n_out = 0;
    acc_cyc.delete();
    changed = 1'b0;
    cipher_in = C1Ct;
    start = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && n_out < 2; i++) begin
      @(posedge clk); #1;
      if (acc_cyc.size() == 1 && !changed) begin
        cipher_in = {$urandom, $urandom, $urandom, $urandom};
        changed = 1'b1;
      end
      if (acc_cyc.size() >= 2) start = 1'b0;
    end
    out_ready = 1'b0;
    check_eq("b2b_outputs", 128'(n_out), 128'd2);
    check_eq("b2b_accepts", 128'(acc_cyc.size()), 128'd2);
    if (acc_cyc.size() >= 2)
      check_eq("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd42);
    check_eq("b2b_idle", 128'(ready_m), 128'd1);

    // reset abort 15 cycles into a block
    cipher_in = C1Ct;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check_eq("abort_busy", 128'(ready_m), 128'd0);
    reset_n = 1'b0;
    #1;
    check_eq("abort_valid", 128'(out_valid_m), 128'd0);
    check_eq("abort_ready", 128'(ready_m), 128'd1);
    check_eq("abort_plain", plain_m, 128'd0);
    check_eq("abort_key_addr", 128'(key_addr_m), 128'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_block(C1Ct, Pt, 10);
    drain(0);

    // AES-256, FIPS-197 C.3
    sel14 = 1'b1;
    @(posedge clk); #1;
    run_block(C3Ct, Pt, 14);
    drain(2);

    check_eq("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
AES_INV_CIPHER_CTRL -- requirements
Module: aes_inv_cipher_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter NR, default 10, number of cipher rounds; legal values 10, 12 and 14.

Ports:
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to decrypt cipher_in; sampled only when ready=1.
REQ-005 SHALL have port cipher_in, input, [0:127]: ciphertext block, captured on an accepted start.
REQ-006 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-007 SHALL have port key_addr, output, 4 bits: round-key index; combinational from FSM state and round counter.
REQ-008 SHALL have port key_in, input, [0:127]: round key for key_addr, valid in the same cycle.
REQ-009 SHALL have port dp_state, output, [0:127]: current state register, fed to the external combinational units.
REQ-010 SHALL have port isr_in, input, [0:127]: InvShiftRows(dp_state).
REQ-011 SHALL have port isb_in, input, [0:127]: InvSubBytes(dp_state).
REQ-012 SHALL have port imc_in, input, [0:127]: InvMixColumns(dp_state).
REQ-013 SHALL have port plain_out, output, [0:127]: equals dp_state; meaningful while out_valid=1.
REQ-014 SHALL have port out_valid, output, 1 bit: plaintext available.
REQ-015 SHALL have port out_ready, input, 1 bit: consumer accepts plain_out.
REQ-016 SHALL have port cur_round, output, 4 bits: round counter value, for debug.

Function
REQ-017 FSM SHALL have states IDLE, ADD_INIT, ISR, ISB, ARK, IMC and DONE; one state step per clock.
REQ-018 IDLE: on start=1, state register SHALL load cipher_in, round SHALL load NR, and the FSM SHALL go to ADD_INIT; start=0 keeps IDLE.
REQ-019 ADD_INIT: key_addr=round; state SHALL load state XOR key_in; round SHALL load round-1; next state ISR.
REQ-020 ISR: state SHALL load isr_in; next state ISB.
REQ-021 ISB: state SHALL load isb_in; next state ARK.
REQ-022 ARK: key_addr=round; state SHALL load state XOR key_in; next state DONE if round==0, else IMC.
REQ-023 IMC: state SHALL load imc_in; round SHALL load round-1; next state ISR.
REQ-024 DONE: out_valid=1; the state register SHALL hold; when out_ready=1 the FSM SHALL go to IDLE and out_valid SHALL drop the next cycle.
REQ-025 key_addr SHALL be 0 in the IDLE, ISR, ISB, IMC and DONE states.
REQ-026 Latency: with start sampled at edge E, out_valid SHALL rise after edge E+4*NR (edge E+40 for NR=10); the input side accepts no new block until DONE→IDLE.
REQ-027 start while ready=0 SHALL be ignored; cipher_in changes while busy SHALL not affect the result.
REQ-028 out_ready=1 outside DONE SHALL have no effect; out_ready held high SHALL cause DONE to last exactly 1 cycle.
REQ-029 The round counter SHALL never decrement below 0; round==0 is reached only on the final ARK.
REQ-030 No state mux or XOR path shall depend on isr_in, isb_in or imc_in outside its own state.

Reset
REQ-031 On reset_n=0, regardless of clk: FSM=IDLE, state register=0, round=0, out_valid=0, ready=1, key_addr=0, plain_out=0.
REQ-032 Reset asserted mid-operation SHALL abort the block with no output; after release, the next start SHALL decrypt normally.
REQ-033 Reset release SHALL be synchronised by the instantiating design; this block assumes a clean deassertion relative to clk.

Verification
REQ-034 FIPS-197 C.1 test: NR=10, key 000102030405060708090a0b0c0d0e0f, bench supplies the expanded schedule and reference units; cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_out 00112233445566778899aabbccddeeff, out_valid rising 40 edges after start.
REQ-035 key_addr trace for REQ-034: the nonzero key_addr values SHALL appear in the order 10,9,8,...,1; the final ARK SHALL present 0.
REQ-036 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and plain_out stable; start pulses during DONE are ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Back-to-back: out_ready tied high with start held high -> second block accepted the cycle after DONE; both plaintexts correct; a new block accepted every 42 cycles.
REQ-038 Reset abort: reset_n pulsed low at cycle 15 of a block -> out_valid=0 and ready=1 immediately; a following C.1 run passes.
REQ-039 NR=14, with AES-256 vector C.3 (key 000102...1f, cipher 8ea2b7ca516745bfeafc49904b496089) -> plain_out 00112233445566778899aabbccddeeff after 56 edges.
